dtw_stream_tx: RTL and testbench

Host-side transmitter for the DTW accelerator's reference-sample stream. It buffers 30-bit samples pushed by the host in a small FIFO and drives the `valid`/`ready` sample port of the DTW top level. Each beat is framed with first-of-sequence and last-of-sequence flags so the DTW controller can delimit sequences of programmable length (1–32 samples, matching the 5-bit DTW index space).

---
 rtl/dtw_stream_tx.sv | 75 +++++++
 tb/tb_dtw_stream_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dtw_stream_tx.sv
// dtw_stream_tx: host sample FIFO feeding the DTW sample port, framing beats
// with first/last flags for sequences of programmable length.
module dtw_stream_tx #(
   parameter int DW    = 30,
   parameter int DEPTH = 16,
   parameter int LEN_W = 5
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic [DW-1:0]            in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LEN_W-1:0]         seq_len_i,
   input  logic                     flush_i,
   output logic [DW+1:0]            Sin_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     seq_done_o,
   output logic                     busy_o,
   output logic [$clog2(DEPTH):0]   fifo_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
   state_t         state;
   logic [DW-1:0]  mem [DEPTH];
   logic [AW:0]    wptr, rptr;
   logic [LEN_W:0] pos, len, len_new;
   logic           empty, full, push, load, acc, fin, start;
   assign empty      = wptr == rptr;
   assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign load       = (!valid_o || ready_i) && !empty;
   assign acc        = valid_o && ready_i;
   assign fin        = acc && Sin_o[DW] && state == STREAM;
   // a load that coincides with the final handshake already opens the next sequence
   assign start      = load && (state != STREAM || fin);
   assign len_new    = {seq_len_i == '0, seq_len_i};
   assign busy_o     = state == STREAM;
   assign fifo_cnt_o = wptr - rptr;
   always_ff @(posedge clk)
      if (push && !flush_i) mem[wptr[AW-1:0]] <= in_data;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         Sin_o      <= '0;
         valid_o    <= 1'b0;
         seq_done_o <= 1'b0;
         wptr       <= '0;
         rptr       <= '0;
         pos        <= '0;
         len        <= '0;
         state      <= IDLE;
      end else if (flush_i) begin
         wptr       <= '0;
         rptr       <= '0;
         valid_o    <= 1'b0;
         seq_done_o <= 1'b0;
         pos        <= '0;
         state      <= IDLE;
      end else begin
         seq_done_o <= fin;
         if (push) wptr <= wptr + 1'b1;
         if (load) begin
            rptr    <= rptr + 1'b1;
            valid_o <= 1'b1;
            Sin_o   <= {start, start ? len_new == (LEN_W+1)'(1) : pos == len - 1'b1, mem[rptr[AW-1:0]]};
            pos     <= start ? (LEN_W+1)'(1) : pos + 1'b1;
            if (start) len <= len_new;
         end else if (acc) begin
            valid_o <= 1'b0;
         end
         state <= start ? STREAM : fin ? DONE : state == DONE ? IDLE : state;
      end
   end
endmodule

// File: tb/tb_dtw_stream_tx.sv
// tb_dtw_stream_tx: scoreboard bench for dtw_stream_tx; expected framed beats
// are queued at push time and compared as the DTW side accepts them.
module tb_dtw_stream_tx;
   logic        clk = 0, nrst = 0;
   logic [29:0] in_data = '0;
   logic        in_valid = 0, in_ready, flush_i = 0, ready_i = 0;
   logic [4:0]  seq_len = 5'd4;
   logic [31:0] Sin_o;
   logic        valid_o, seq_done_o, busy_o;
   logic [4:0]  fifo_cnt_o;
   logic [31:0] sb[$];
   logic [31:0] held;
   logic        hold_v = 0, exp_done = 0;
   int          checks = 0, errors = 0, mpos = 0, mlen = 0, done_cnt = 0, busy_cnt = 0;

   dtw_stream_tx dut (
      .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .seq_len_i(seq_len), .flush_i(flush_i), .Sin_o(Sin_o), .valid_o(valid_o),
      .ready_i(ready_i), .seq_done_o(seq_done_o), .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic void model_push(input logic [29:0] d);
      logic f, l;
      if (mpos == 0) mlen = (seq_len == 0) ? 32 : int'(seq_len);
      f = mpos == 0;
      l = mpos == mlen - 1;
      sb.push_back({f, l, d});
      mpos = l ? 0 : mpos + 1;
   endfunction

   task automatic push(input logic [29:0] d);
      int n = 0;
      in_valid = 1;
      in_data  = d;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("push_timeout", in_ready, 1);
      @(posedge clk);
      model_push(d);
      #1 in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1 chk("drain", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!nrst) begin
         hold_v   = 0;
         exp_done = 0;
      end else begin
         chk("seq_done", seq_done_o, exp_done);
         if (seq_done_o) done_cnt++;
         if (busy_o) busy_cnt++;
         if (hold_v) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_data", Sin_o, held);
         end
         exp_done = 0;
         if (valid_o && ready_i && !flush_i) begin
            if (sb.size() == 0) chk("extra_beat", sb.size(), 1);
            else begin
               chk("beat", Sin_o, sb.pop_front());
               exp_done = Sin_o[30];
            end
         end
         hold_v = valid_o && !ready_i && !flush_i;
         held   = Sin_o;
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #2 nrst = 1;
      @(posedge clk); #1;
      chk("rst_sin", Sin_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_cnt", fifo_cnt_o, 0);
      // length 4, back-to-back
      ready_i = 1; seq_len = 5'd4; done_cnt = 0;
      for (int i = 0; i < 4; i++) push(30'h11 + 30'(i));
      drain();
      chk("t1_done_cnt", done_cnt, 1);
      // length 1, latency and single busy cycle
      seq_len = 5'd1; done_cnt = 0; busy_cnt = 0;
      push(30'h5);
      chk("lat_before", valid_o, 0);
      @(posedge clk); #1;
      chk("lat_after", valid_o, 1);
      chk("len1_sin", Sin_o, 32'hC000_0005);
      drain();
      chk("len1_busy", busy_cnt, 1);
      chk("len1_done", done_cnt, 1);
      // length 32 with random backpressure
      seq_len = 5'd0; done_cnt = 0;
      fork
         for (int i = 0; i < 32; i++) push(30'h100 + 30'(i));
         begin
            for (int i = 0; i < 80; i++) begin
               ready_i = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            ready_i = 1;
         end
      join
      drain();
      chk("len32_done", done_cnt, 1);
      // fill FIFO with output stalled
      ready_i = 0; seq_len = 5'd17;
      for (int i = 0; i < 16; i++) push(30'h200 + 30'(i));
      chk("near_full_ready", in_ready, 1);
      chk("near_full_cnt", fifo_cnt_o, 15);
      push(30'h210);
      chk("full_ready", in_ready, 0);
      chk("full_cnt", fifo_cnt_o, 16);
      ready_i = 1;
      drain();
      chk("wrap_cnt", fifo_cnt_o, 0);
      // mid-sequence length change is ignored
      seq_len = 5'd3;
      push(30'h301);
      @(posedge clk); #1 seq_len = 5'd2;
      push(30'h302);
      push(30'h303);
      push(30'h304);
      push(30'h305);
      drain();
      // flush with push and handshake in the same cycle
      ready_i = 0; seq_len = 5'd4;
      push(30'h21); push(30'h22); push(30'h23);
      flush_i = 1; in_valid = 1; in_data = 30'h99; ready_i = 1;
      @(posedge clk);
      sb.delete(); mpos = 0;
      #1 flush_i = 0; in_valid = 0;
      chk("flush_valid", valid_o, 0);
      chk("flush_cnt", fifo_cnt_o, 0);
      chk("flush_busy", busy_o, 0);
      push(30'h31);
      drain();
      // asynchronous reset mid-operation
      ready_i = 0;
      push(30'h41); push(30'h42);
      @(posedge clk); #3 nrst = 0;
      #1;
      chk("arst_sin", Sin_o, 0);
      chk("arst_valid", valid_o, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_done", seq_done_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_cnt", fifo_cnt_o, 0);
      sb.delete(); mpos = 0;
      repeat (2) @(posedge clk);
      #2 nrst = 1;
      @(posedge clk); #1;
      ready_i = 1; seq_len = 5'd1;
      push(30'h51);
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got 1 exp 0");
      $fatal(1);
   end
endmodule
